// File: rtl/lstm_step_scheduler_if.sv
// rtl/lstm_step_scheduler_if.sv - host control and stage handshakes around the LSTM timestep scheduler
interface lstm_step_scheduler_if #(
  parameter int T_W = 8
);
  logic           start;
  logic [T_W-1:0] num_steps;
  logic           x_load_req;
  logic           x_load_done;
  logic           gate_idle;
  logic           gate_done;
  logic           out_idle;
  logic           out_done;
  logic           h_rd_bank;
  logic           h_wr_bank;
  logic [T_W-1:0] step_idx;
  logic           busy;
  logic           done;
  logic           err;

  modport master (
    input  start, num_steps, x_load_done, gate_done, out_done,
    output x_load_req, gate_idle, out_idle, h_rd_bank, h_wr_bank,
           step_idx, busy, done, err
  );

  modport slave (
    output start, num_steps, x_load_done, gate_done, out_done,
    input  x_load_req, gate_idle, out_idle, h_rd_bank, h_wr_bank,
           step_idx, busy, done, err
  );
endinterface

// File: rtl/lstm_step_scheduler.sv
// rtl/lstm_step_scheduler.sv - per-timestep sequencer: x load, gate SpMV, output stage, H bank swap
module lstm_step_scheduler #(
  parameter int              T_W     = 8,
  parameter int              TO_W    = 16,
  parameter logic [TO_W-1:0] TIMEOUT = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  lstm_step_scheduler_if.master sched
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_X,
    S_WAIT_X,
    S_GATE,
    S_WAIT_GATE,
    S_OUT,
    S_OUT_GUARD,
    S_WAIT_OUT,
    S_NEXT,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [TO_W-1:0] WDOG_LAST = TIMEOUT - 1'b1;

  state_t          state;
  state_t          state_nxt;
  logic [T_W-1:0]  steps_q;
  logic [T_W-1:0]  steps_nxt;
  logic [T_W-1:0]  idx_q;
  logic [T_W-1:0]  idx_nxt;
  logic            bank_q;
  logic            bank_nxt;
  logic [TO_W-1:0] wdog_q;
  logic [TO_W-1:0] wdog_nxt;
  logic            in_wait;
  logic            wait_hit;
  logic            accept;

  logic            wr_bank_q;
  logic            x_req_q;
  logic            gate_q;
  logic            out_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;

  // Pulse/status outputs are decoded from the next state so they line up
  // exactly with the state they belong to while still coming from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      steps_q   <= '0;
      idx_q     <= '0;
      bank_q    <= 1'b0;
      wdog_q    <= '0;
      wr_bank_q <= 1'b1;
      x_req_q   <= 1'b0;
      gate_q    <= 1'b0;
      out_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      steps_q   <= steps_nxt;
      idx_q     <= idx_nxt;
      bank_q    <= bank_nxt;
      wdog_q    <= wdog_nxt;
      wr_bank_q <= ~bank_nxt;
      x_req_q   <= (state_nxt == S_LOAD_X);
      gate_q    <= (state_nxt == S_GATE);
      out_q     <= (state_nxt == S_OUT);
      busy_q    <= (state_nxt != S_IDLE);
      done_q    <= (state_nxt == S_DONE);
      err_q     <= (state_nxt == S_ERR);
    end
  end

  always_comb begin
    state_nxt = state;
    steps_nxt = steps_q;
    idx_nxt   = idx_q;
    bank_nxt  = bank_q;
    wdog_nxt  = wdog_q;
    in_wait   = 1'b0;
    wait_hit  = 1'b0;
    accept    = 1'b0;

    case (state)
      S_IDLE, S_ERR: accept = sched.start;
      S_LOAD_X: begin
        state_nxt = S_WAIT_X;
        wdog_nxt  = '0;
      end
      S_WAIT_X: begin
        in_wait  = 1'b1;
        wait_hit = sched.x_load_done;
        if (wait_hit) state_nxt = S_GATE;
      end
      S_GATE: begin
        state_nxt = S_WAIT_GATE;
        wdog_nxt  = '0;
      end
      S_WAIT_GATE: begin
        in_wait  = 1'b1;
        wait_hit = sched.gate_done;
        if (wait_hit) state_nxt = S_OUT;
      end
      S_OUT: state_nxt = S_OUT_GUARD;
      // out_done may still be the previous step's level here; don't look at it yet.
      S_OUT_GUARD: begin
        state_nxt = S_WAIT_OUT;
        wdog_nxt  = '0;
      end
      S_WAIT_OUT: begin
        in_wait  = 1'b1;
        wait_hit = sched.out_done;
        if (wait_hit) state_nxt = S_NEXT;
      end
      S_NEXT: begin
        bank_nxt = ~bank_q;
        if (idx_q == steps_q - 1'b1) begin
          state_nxt = S_DONE;
        end else begin
          idx_nxt   = idx_q + 1'b1;
          state_nxt = S_LOAD_X;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    // The awaited input wins on the last allowed cycle.
    if (in_wait && !wait_hit) begin
      if (wdog_q == WDOG_LAST) state_nxt = S_ERR;
      else                     wdog_nxt  = wdog_q + 1'b1;
    end

    if (accept) begin
      steps_nxt = sched.num_steps;
      idx_nxt   = '0;
      bank_nxt  = 1'b0;
      state_nxt = (sched.num_steps == '0) ? S_DONE : S_LOAD_X;
    end
  end

  assign sched.x_load_req = x_req_q;
  assign sched.gate_idle  = gate_q;
  assign sched.out_idle   = out_q;
  assign sched.h_rd_bank  = bank_q;
  assign sched.h_wr_bank  = wr_bank_q;
  assign sched.step_idx   = idx_q;
  assign sched.busy       = busy_q;
  assign sched.done       = done_q;
  assign sched.err        = err_q;

  a_bank_pair: assert property (@(posedge clk) disable iff (rst)
    sched.h_wr_bank == ~sched.h_rd_bank);
  a_one_pulse: assert property (@(posedge clk) disable iff (rst)
    $onehot0({sched.x_load_req, sched.gate_idle, sched.out_idle, sched.done}));
  a_err_busy: assert property (@(posedge clk) disable iff (rst)
    sched.err |-> sched.busy);

endmodule
